// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: writeback source selects,
// load-type encodings and the link-address offset.
package mips_pkg;

    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
    localparam logic [1:0] MEMTOREG_LINK = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    // Return address of a jump-and-link sits past the delay slot.
    localparam int unsigned LINK_OFFSET = 8;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the addressed byte/half out of a little-endian memory
// word and sign- or zero-extends it. Unknown load types behave as LW.
module load_align
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr_lo,
    input  logic [2:0]    loadtype,
    output logic [DW-1:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane extraction then extension by load type.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (loadtype)
            LD_LB:   aligned = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  aligned = {{(DW-8){1'b0}}, byte_sel};
            LD_LH:   aligned = {{(DW-16){half_sel[15]}}, half_sel};
            LD_LHU:  aligned = {{(DW-16){1'b0}}, half_sel};
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, writeback source select, register
// file write port and retired-instruction counter.
// Optional feature: define WB_BYPASS_EN to add a combinational write-through
// path so an ID-stage read in the same cycle as a WB write sees the new value.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [1:0]       mem_memtoreg,
    input  logic [2:0]       mem_loadtype,
    input  logic [1:0]       mem_addr_lo,
    input  logic [DW-1:0]    mem_aluresult,
    input  logic [DW-1:0]    mem_rdata,
    input  logic [DW-1:0]    mem_pc,
    input  logic [AW-1:0]    mem_dest,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0]    id_rs_addr,
    input  logic [AW-1:0]    id_rt_addr,
    input  logic [DW-1:0]    rf_rdata1,
    input  logic [DW-1:0]    rf_rdata2,
    output logic [DW-1:0]    id_rs_data,
    output logic [DW-1:0]    id_rt_data,
`endif
    output logic             RegWriteWB,
    output logic [AW-1:0]    regwriteaddrWB,
    output logic [DW-1:0]    regwritedataWB,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [DW-1:0] LINK_OFF = DW'(LINK_OFFSET);

    logic             valid_q;
    logic             regwrite_q;
    logic [1:0]       memtoreg_q;
    logic [2:0]       loadtype_q;
    logic [1:0]       addr_lo_q;
    logic [DW-1:0]    aluresult_q;
    logic [DW-1:0]    rdata_q;
    logic [DW-1:0]    pc_q;
    logic [AW-1:0]    dest_q;
    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] retire_d;
    logic [DW-1:0]    load_data;

    // The instruction sitting in WB retires unless the stage is held;
    // a same-cycle flush only kills the incoming instruction.
    always_comb begin
        retire_d = retire_q;
        if (valid_q && !stall_i) begin
            retire_d = retire_q + CNT_W'(1);
        end
    end

    // Stage register: flush beats stall beats capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= '0;
            loadtype_q  <= '0;
            addr_lo_q   <= '0;
            aluresult_q <= '0;
            rdata_q     <= '0;
            pc_q        <= '0;
            dest_q      <= '0;
            retire_q    <= '0;
        end else begin
            retire_q <= retire_d;
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (!stall_i) begin
                valid_q     <= mem_valid;
                regwrite_q  <= mem_regwrite;
                memtoreg_q  <= mem_memtoreg;
                loadtype_q  <= mem_loadtype;
                addr_lo_q   <= mem_addr_lo;
                aluresult_q <= mem_aluresult;
                rdata_q     <= mem_rdata;
                pc_q        <= mem_pc;
                dest_q      <= mem_dest;
            end
        end
    end

    load_align #(.DW(DW)) u_load_align (
        .rdata    (rdata_q),
        .addr_lo  (addr_lo_q),
        .loadtype (loadtype_q),
        .aligned  (load_data)
    );

    // Writeback source select; the reserved encoding falls back to ALU.
    always_comb begin
        case (memtoreg_q)
            MEMTOREG_LOAD: regwritedataWB = load_data;
            MEMTOREG_LINK: regwritedataWB = pc_q + LINK_OFF;
            default:       regwritedataWB = aluresult_q;
        endcase
    end

    // Writes to r0 are suppressed; a stalled write simply repeats.
    always_comb begin
        RegWriteWB     = valid_q && regwrite_q && (dest_q != '0);
        regwriteaddrWB = dest_q;
        wb_valid       = valid_q;
        retire_count   = retire_q;
    end

`ifdef WB_BYPASS_EN
    // Write-through so the ID stage never reads stale RF data.
    always_comb begin
        id_rs_data = rf_rdata1;
        id_rt_data = rf_rdata2;
        if (RegWriteWB && (id_rs_addr == regwriteaddrWB)) begin
            id_rs_data = regwritedataWB;
        end
        if (RegWriteWB && (id_rt_addr == regwriteaddrWB)) begin
            id_rt_data = regwritedataWB;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  m2r;
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  dest;
    } in_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    in_t         in = '0;
    logic        RegWriteWB;
    logic [4:0]  regwriteaddrWB;
    logic [31:0] regwritedataWB;
    logic        wb_valid;
    logic [31:0] retire_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  id_rs_addr = '0;
    logic [4:0]  id_rt_addr = '0;
    logic [31:0] rf_rdata1 = '0;
    logic [31:0] rf_rdata2 = '0;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall),
        .flush_i        (flush),
        .mem_valid      (in.valid),
        .mem_regwrite   (in.regwrite),
        .mem_memtoreg   (in.m2r),
        .mem_loadtype   (in.lt),
        .mem_addr_lo    (in.lo),
        .mem_aluresult  (in.alu),
        .mem_rdata      (in.rdata),
        .mem_pc         (in.pc),
        .mem_dest       (in.dest),
`ifdef WB_BYPASS_EN
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
`endif
        .RegWriteWB     (RegWriteWB),
        .regwriteaddrWB (regwriteaddrWB),
        .regwritedataWB (regwritedataWB),
        .wb_valid       (wb_valid),
        .retire_count   (retire_count)
    );

    // Reference: value an instruction writes back, from its captured fields.
    function automatic logic [31:0] exp_data(input in_t f);
        logic [31:0] b;
        logic [31:0] h;
        b = (f.rdata >> (8 * f.lo)) & 32'h0000_00FF;
        h = (f.rdata >> (16 * f.lo[1])) & 32'h0000_FFFF;
        if (f.m2r == 2'd2) return f.pc + 32'd8;
        if (f.m2r != 2'd1) return f.alu;
        case (f.lt)
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2:    return h;
            3'd3:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            default: return f.rdata;
        endcase
    endfunction

    // Model state: the instruction held in WB and the retire tally.
    logic        m_valid;
    in_t         m_f;
    logic [31:0] m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_f     = '0;
            m_cnt   = '0;
        end else begin
            if (m_valid && !stall) m_cnt = m_cnt + 32'd1;
            if (flush) m_valid = 1'b0;
            else if (!stall) begin
                m_valid = in.valid;
                m_f     = in;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
            chk("retire_count", retire_count, m_cnt);
            chk("RegWriteWB", {31'd0, RegWriteWB},
                {31'd0, m_valid && m_f.regwrite && (m_f.dest != 5'd0)});
            if (m_valid) begin
                chk("regwriteaddrWB", {27'd0, regwriteaddrWB}, {27'd0, m_f.dest});
                chk("regwritedataWB", regwritedataWB, exp_data(m_f));
            end
`ifdef WB_BYPASS_EN
            begin
                logic we;
                we = m_valid && m_f.regwrite && (m_f.dest != 5'd0);
                chk("id_rs_data", id_rs_data,
                    (we && id_rs_addr == m_f.dest) ? exp_data(m_f) : rf_rdata1);
                chk("id_rt_data", id_rt_data,
                    (we && id_rt_addr == m_f.dest) ? exp_data(m_f) : rf_rdata2);
            end
`endif
        end
    end

    task automatic drive(input in_t v, input logic st, input logic fl);
        @(negedge clk);
        #1;
        in    = v;
        stall = st;
        flush = fl;
        @(posedge clk);
        #2;
    endtask

    function automatic in_t mk(input logic [1:0] m2r, input logic [2:0] lt, input logic [1:0] lo,
                               input logic [31:0] alu, input logic [31:0] rdata,
                               input logic [31:0] pc, input logic [4:0] dest);
        in_t v;
        v.valid = 1'b1; v.regwrite = 1'b1; v.m2r = m2r; v.lt = lt; v.lo = lo;
        v.alu = alu; v.rdata = rdata; v.pc = pc; v.dest = dest;
        return v;
    endfunction

    in_t bubble;
    in_t v;

    initial begin
        bubble = '0;
        #1 reset = 1'b1;
        #3;
        chk("reset RegWriteWB", {31'd0, RegWriteWB}, 32'd0);
        chk("reset addr", {27'd0, regwriteaddrWB}, 32'd0);
        chk("reset data", regwritedataWB, 32'd0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset count", retire_count, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        checking = 1'b1;

        // ALU writeback and its retire one edge later.
        drive(mk(2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 5'd5), 1'b0, 1'b0);
        chk("alu we", {31'd0, RegWriteWB}, 32'd1);
        chk("alu addr", {27'd0, regwriteaddrWB}, 32'd5);
        chk("alu data", regwritedataWB, 32'h1234_5678);
        chk("alu count before", retire_count, 32'd0);
        drive(bubble, 1'b0, 1'b0);
        chk("alu count after", retire_count, 32'd1);

        // Sub-word loads from 0x80FF_7F01.
        drive(mk(2'd1, 3'd3, 2'd3, 32'd0, 32'h80FF_7F01, 32'd0, 5'd7), 1'b0, 1'b0);
        chk("LB lo3", regwritedataWB, 32'hFFFF_FF80);
        drive(mk(2'd1, 3'd4, 2'd3, 32'd0, 32'h80FF_7F01, 32'd0, 5'd7), 1'b0, 1'b0);
        chk("LBU lo3", regwritedataWB, 32'h0000_0080);
        drive(mk(2'd1, 3'd1, 2'd2, 32'd0, 32'h80FF_7F01, 32'd0, 5'd7), 1'b0, 1'b0);
        chk("LH lo2", regwritedataWB, 32'hFFFF_80FF);
        drive(mk(2'd1, 3'd2, 2'd0, 32'd0, 32'h80FF_7F01, 32'd0, 5'd7), 1'b0, 1'b0);
        chk("LHU lo0", regwritedataWB, 32'h0000_7F01);
        drive(mk(2'd1, 3'd0, 2'd1, 32'd0, 32'h80FF_7F01, 32'd0, 5'd7), 1'b0, 1'b0);
        chk("LW lo1", regwritedataWB, 32'h80FF_7F01);

        // Link address wraps.
        drive(mk(2'd2, 3'd0, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 5'd31), 1'b0, 1'b0);
        chk("link data", regwritedataWB, 32'h0000_0004);
        chk("link addr", {27'd0, regwriteaddrWB}, 32'd31);

        // r0 destination: no write, still retires.
        drive(mk(2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd0), 1'b0, 1'b0);
        chk("r0 we", {31'd0, RegWriteWB}, 32'd0);
        drive(bubble, 1'b0, 1'b0);
        chk("r0 count", retire_count, 32'd8);

        // Stall holds for three cycles, then stall+flush bubbles.
        drive(mk(2'd0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'd0, 32'd0, 5'd9), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(mk(2'd0, 3'd0, 2'd0, 32'h1111_1111, 32'd0, 32'd0, 5'd3), 1'b1, 1'b0);
            chk("stall we", {31'd0, RegWriteWB}, 32'd1);
            chk("stall addr", {27'd0, regwriteaddrWB}, 32'd9);
            chk("stall data", regwritedataWB, 32'h0BAD_F00D);
            chk("stall count", retire_count, 32'd8);
        end
        drive(mk(2'd0, 3'd0, 2'd0, 32'h2222_2222, 32'd0, 32'd0, 5'd4), 1'b1, 1'b1);
        chk("stall+flush valid", {31'd0, wb_valid}, 32'd0);
        chk("stall+flush count", retire_count, 32'd8);
        drive(mk(2'd0, 3'd0, 2'd0, 32'h3333_3333, 32'd0, 32'd0, 5'd4), 1'b0, 1'b0);
        drive(bubble, 1'b0, 1'b1);
        chk("flush retires", retire_count, 32'd9);
        chk("flush valid", {31'd0, wb_valid}, 32'd0);

`ifdef WB_BYPASS_EN
        drive(mk(2'd0, 3'd0, 2'd0, 32'h0000_00AA, 32'd0, 32'd0, 5'd5), 1'b0, 1'b0);
        id_rs_addr = 5'd5;
        rf_rdata1  = 32'h0000_0055;
        #1;
        chk("bypass rs", id_rs_data, 32'h0000_00AA);
`endif

        // Reset mid-stream clears immediately.
        drive(mk(2'd0, 3'd0, 2'd0, 32'h4444_4444, 32'd0, 32'd0, 5'd6), 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("mid reset we", {31'd0, RegWriteWB}, 32'd0);
        chk("mid reset count", retire_count, 32'd0);
        chk("mid reset valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            v.valid    = ($urandom_range(0, 9) < 8);
            v.regwrite = ($urandom_range(0, 9) < 8);
            v.m2r      = 2'($urandom_range(0, 3));
            v.lt       = 3'($urandom_range(0, 7));
            v.lo       = 2'($urandom_range(0, 3));
            v.alu      = $urandom;
            v.rdata    = $urandom;
            v.pc       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            v.dest     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
`ifdef WB_BYPASS_EN
            id_rs_addr = 5'($urandom_range(0, 31));
            id_rt_addr = ($urandom_range(0, 1) == 1) ? m_f.dest : 5'($urandom_range(0, 31));
            rf_rdata1  = $urandom;
            rf_rdata2  = $urandom;
`endif
            drive(v, ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
